// File: rtl/umni_pkg.sv
// umni_pkg: definitions shared by the UMNI sensor reader.
//   estado_t    - reader FSM states
//   UMIDADE_MAX - ceiling applied to received humidity values
//   IDX_W       - width of the sensor index / sensor_sel
//   satura()    - clamps a received 7-bit value to UMIDADE_MAX
package umni_pkg;

  localparam int unsigned UMIDADE_MAX = 100;
  localparam int unsigned IDX_W       = 2;

  typedef enum logic [3:0] {
    OCIOSO,
    REQUISITA,
    ESPERA_START,
    START,
    DADOS,
    PARIDADE,
    STOP,
    ARMAZENA,
    FALHA,
    PROXIMO
  } estado_t;

  function automatic logic [6:0] satura(input logic [6:0] v);
    return (v > 7'(UMIDADE_MAX)) ? 7'(UMIDADE_MAX) : v;
  endfunction

endpackage

// File: rtl/umni_rx_bit.sv
// umni_rx_bit: serial line conditioning for the UMNI sensor reader.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_linha        - raw shared serial line (asynchronous, idle high)
//   i_carrega      - start-bit falling edge accepted: arm the half-bit timer
//   i_ativo        - frame in progress: let the sample timer run
//   o_linha        - line after the 2-flop synchronizer (reset to 1)
//   o_queda        - one-cycle strobe on a synchronized falling edge
//   o_amostra      - one-cycle mid-bit sample strobe
module umni_rx_bit
  import umni_pkg::*;
#(
  parameter int unsigned BIT_CICLOS = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_linha,
  input  logic i_carrega,
  input  logic i_ativo,
  output logic o_linha,
  output logic o_queda,
  output logic o_amostra
);

  localparam int unsigned CW = $clog2(BIT_CICLOS);
  localparam logic [CW-1:0] MEIO_BIT  = CW'(BIT_CICLOS / 2 - 1);
  localparam logic [CW-1:0] BIT_TOTAL = CW'(BIT_CICLOS - 1);

  logic          r_sinc1;
  logic          r_sinc2;
  logic          r_sinc_ant;
  logic [CW-1:0] r_cont;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sinc1    <= 1'b1;
      r_sinc2    <= 1'b1;
      r_sinc_ant <= 1'b1;
    end else begin
      r_sinc1    <= i_linha;
      r_sinc2    <= r_sinc1;
      r_sinc_ant <= r_sinc2;
    end
  end

  // First tick lands half a bit after the start edge, then one per bit,
  // so every sample sits in the middle of its bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cont <= '0;
    end else if (i_carrega) begin
      r_cont <= MEIO_BIT;
    end else if (i_ativo) begin
      r_cont <= (r_cont == '0) ? BIT_TOTAL : r_cont - 1'b1;
    end
  end

  assign o_linha   = r_sinc2;
  assign o_queda   = r_sinc_ant & ~r_sinc2;
  assign o_amostra = i_ativo && (r_cont == '0);

endmodule

// File: rtl/umni_leitor_sensores.sv
// umni_leitor_sensores: polls the four UMNI humidity sensors over one shared
// single-wire line and keeps the last good value of each.
//   clock_geral, reset_geral_n - clock, asynchronous active-low reset
//   iniciar_varredura          - one-cycle pulse, starts a scan when idle
//   sensor_dado                - shared serial line (async, idle high)
//   sensor_req, sensor_sel     - request pulse and address of the polled sensor
//   sensor1..sensor4           - last good humidity (clamped to 100)
//   amostra_valida             - one-cycle pulse at the end of each scan
//   erro_sensor                - per-sensor error flags of the last scan
//   ocupado                    - high while a scan is in progress
// Frame: start 0, 7 data bits LSB first, even parity, stop 1.
// Macro UMNI_PARIDADE_EN: when defined, a parity mismatch marks the sensor
// as failed (after the stop bit); otherwise the parity bit is discarded.
module umni_leitor_sensores
  import umni_pkg::*;
#(
  parameter int unsigned BIT_CICLOS        = 50,
  parameter int unsigned TIMEOUT_CICLOS    = 2000,
  parameter int unsigned PERIODO_VARREDURA = 100000
) (
  input  logic             clock_geral,
  input  logic             reset_geral_n,
  input  logic             iniciar_varredura,
  input  logic             sensor_dado,
  output logic             sensor_req,
  output logic [IDX_W-1:0] sensor_sel,
  output logic [6:0]       sensor1,
  output logic [6:0]       sensor2,
  output logic [6:0]       sensor3,
  output logic [6:0]       sensor4,
  output logic             amostra_valida,
  output logic [3:0]       erro_sensor,
  output logic             ocupado
);

  localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TIMEOUT_ULT = (TIMEOUT_CICLOS > 1) ? TW'(TIMEOUT_CICLOS - 1) : '0;
  localparam int unsigned PW = (PERIODO_VARREDURA > 1) ? $clog2(PERIODO_VARREDURA) : 1;
  localparam logic [PW-1:0] PERIODO_ULT = (PERIODO_VARREDURA > 1) ? PW'(PERIODO_VARREDURA - 1) : '0;

  estado_t          r_estado;
  estado_t          w_prox;
  logic [IDX_W-1:0] r_indice;
  logic [TW-1:0]    r_cont_to;
  logic [6:0]       r_dado;
  logic [2:0]       r_nbits;
  logic [3:0]       r_acc;
  logic [6:0]       r_sensor [4];
  logic             r_req;
  logic             r_valida;
  logic             r_ocupado;
  logic [3:0]       r_erro;
  logic [PW-1:0]    r_periodo;

  logic w_linha;
  logic w_queda;
  logic w_amostra;
  logic w_ativo;
  logic w_carrega;
  logic w_gatilho;
  logic w_periodo_fim;
  logic w_fim_varredura;
  logic w_par_falha;

  assign w_ativo   = r_estado inside {START, DADOS, PARIDADE, STOP};
  assign w_carrega = (r_estado == ESPERA_START) && w_queda;

  umni_rx_bit #(
    .BIT_CICLOS(BIT_CICLOS)
  ) u_rx_bit (
    .i_clk     (clock_geral),
    .i_rst_n   (reset_geral_n),
    .i_linha   (sensor_dado),
    .i_carrega (w_carrega),
    .i_ativo   (w_ativo),
    .o_linha   (w_linha),
    .o_queda   (w_queda),
    .o_amostra (w_amostra)
  );

  assign w_periodo_fim   = (PERIODO_VARREDURA != 0) && (r_periodo == PERIODO_ULT);
  assign w_gatilho       = iniciar_varredura || w_periodo_fim;
  assign w_fim_varredura = (r_estado == PROXIMO) && (r_indice == '1);

`ifdef UMNI_PARIDADE_EN
  logic r_par_erro;

  // Mismatch is only acted on at the stop bit, keeping the line aligned.
  always_ff @(posedge clock_geral or negedge reset_geral_n) begin
    if (!reset_geral_n) begin
      r_par_erro <= 1'b0;
    end else if (r_estado == ESPERA_START) begin
      r_par_erro <= 1'b0;
    end else if ((r_estado == PARIDADE) && w_amostra) begin
      r_par_erro <= ^{r_dado, w_linha};
    end
  end

  assign w_par_falha = r_par_erro;
`else
  assign w_par_falha = 1'b0;
`endif

  always_ff @(posedge clock_geral or negedge reset_geral_n) begin
    if (!reset_geral_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      OCIOSO:       if (w_gatilho) w_prox = REQUISITA;
      REQUISITA:    w_prox = ESPERA_START;
      ESPERA_START: begin
        if (w_queda) begin
          w_prox = START;
        end else if (r_cont_to == TIMEOUT_ULT) begin
          w_prox = FALHA;
        end
      end
      START:        if (w_amostra) w_prox = w_linha ? FALHA : DADOS;
      DADOS:        if (w_amostra && (r_nbits == 3'd6)) w_prox = PARIDADE;
      PARIDADE:     if (w_amostra) w_prox = STOP;
      STOP: begin
        if (w_amostra) begin
          w_prox = (!w_linha || w_par_falha) ? FALHA : ARMAZENA;
        end
      end
      ARMAZENA:     w_prox = PROXIMO;
      FALHA:        w_prox = PROXIMO;
      PROXIMO:      w_prox = (r_indice == '1) ? OCIOSO : REQUISITA;
      default:      w_prox = OCIOSO;
    endcase
  end

  // Sensor value is written on the stop-bit sample itself so it shows up
  // the cycle after; ARMAZENA only sequences to the next sensor.
  // Flag outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock_geral or negedge reset_geral_n) begin
    if (!reset_geral_n) begin
      r_indice  <= '0;
      r_cont_to <= '0;
      r_dado    <= '0;
      r_nbits   <= '0;
      r_acc     <= '0;
      r_req     <= 1'b0;
      r_valida  <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= '0;
      r_periodo <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_sensor[i] <= '0;
      end
    end else begin
      r_req     <= (w_prox == REQUISITA);
      r_ocupado <= (w_prox != OCIOSO);
      r_valida  <= w_fim_varredura;

      if ((PERIODO_VARREDURA == 0) || w_periodo_fim) begin
        r_periodo <= '0;
      end else begin
        r_periodo <= r_periodo + 1'b1;
      end

      r_cont_to <= (r_estado == ESPERA_START) ? r_cont_to + 1'b1 : '0;

      case (r_estado)
        OCIOSO: begin
          if (w_gatilho) begin
            r_indice <= '0;
            r_acc    <= '0;
          end
        end
        ESPERA_START: r_nbits <= '0;
        DADOS: begin
          if (w_amostra) begin
            r_dado  <= {w_linha, r_dado[6:1]};
            r_nbits <= r_nbits + 1'b1;
          end
        end
        STOP: begin
          if (w_prox == ARMAZENA) begin
            r_sensor[r_indice] <= satura(r_dado);
          end
        end
        FALHA: r_acc[r_indice] <= 1'b1;
        PROXIMO: begin
          if (w_fim_varredura) begin
            r_erro <= r_acc;
          end else begin
            r_indice <= r_indice + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sensor_req     = r_req;
  assign sensor_sel     = r_indice;
  assign sensor1        = r_sensor[0];
  assign sensor2        = r_sensor[1];
  assign sensor3        = r_sensor[2];
  assign sensor4        = r_sensor[3];
  assign amostra_valida = r_valida;
  assign erro_sensor    = r_erro;
  assign ocupado        = r_ocupado;

endmodule

// File: tb/tb_umni_leitor_sensores.sv
module tb_umni_leitor_sensores;

  localparam int unsigned BIT = 8;
  localparam int M_OK     = 0;
  localparam int M_MUDO   = 1;
  localparam int M_STOP   = 2;
  localparam int M_PAR    = 3;
  localparam int M_GLITCH = 4;

  logic       clock_geral = 1'b0;
  logic       reset_geral_n;
  logic       iniciar_varredura;
  logic       sensor_dado;
  logic       sensor_req;
  logic [1:0] sensor_sel;
  logic [6:0] sensor1, sensor2, sensor3, sensor4;
  logic       amostra_valida;
  logic [3:0] erro_sensor;
  logic       ocupado;

  umni_leitor_sensores #(
    .BIT_CICLOS(8),
    .TIMEOUT_CICLOS(64),
    .PERIODO_VARREDURA(0)
  ) dut (
    .clock_geral      (clock_geral),
    .reset_geral_n    (reset_geral_n),
    .iniciar_varredura(iniciar_varredura),
    .sensor_dado      (sensor_dado),
    .sensor_req       (sensor_req),
    .sensor_sel       (sensor_sel),
    .sensor1          (sensor1),
    .sensor2          (sensor2),
    .sensor3          (sensor3),
    .sensor4          (sensor4),
    .amostra_valida   (amostra_valida),
    .erro_sensor      (erro_sensor),
    .ocupado          (ocupado)
  );

  always #5 clock_geral = ~clock_geral;

  int total = 0;
  int bad   = 0;

  int         cnt_req = 0;
  int         cnt_val = 0;
  int         sel_log[$];
  int         req_q[$];
  int         modo[4];
  logic [6:0] valor[4];
  logic [6:0] exp_sens[4];
  logic [3:0] exp_err;
  int         fase = 0;
  bit         model_busy = 1'b0;

  logic [6:0] obs[4];
  assign obs[0] = sensor1;
  assign obs[1] = sensor2;
  assign obs[2] = sensor3;
  assign obs[3] = sensor4;

  // Request / end-of-scan monitor.
  initial begin
    forever begin
      @(negedge clock_geral);
      if (sensor_req === 1'b1) begin
        cnt_req++;
        sel_log.push_back(int'(sensor_sel));
        req_q.push_back(int'(sensor_sel));
      end
      if (amostra_valida === 1'b1) cnt_val++;
    end
  end

  task automatic envia(input logic [6:0] v, input logic par, input logic stop);
    fase = 1;
    sensor_dado = 1'b0;
    repeat (BIT) @(negedge clock_geral);
    fase = 2;
    for (int i = 0; i < 7; i++) begin
      sensor_dado = v[i];
      repeat (BIT) @(negedge clock_geral);
    end
    fase = 3;
    sensor_dado = par;
    repeat (BIT) @(negedge clock_geral);
    sensor_dado = stop;
    repeat (BIT) @(negedge clock_geral);
    sensor_dado = 1'b1;
    fase = 0;
  endtask

  // Sensor-side model: answers each request in order, per configured mode.
  initial begin
    sensor_dado = 1'b1;
    forever begin
      @(negedge clock_geral);
      if (req_q.size() != 0) begin
        int s;
        s = req_q.pop_front();
        model_busy = 1'b1;
        repeat (3) @(negedge clock_geral);
        case (modo[s])
          M_MUDO: ;
          M_STOP: envia(valor[s], ^valor[s], 1'b0);
          M_PAR:  envia(valor[s], ~(^valor[s]), 1'b1);
          M_GLITCH: begin
            sensor_dado = 1'b0;
            repeat (2) @(negedge clock_geral);
            sensor_dado = 1'b1;
            repeat (6) @(negedge clock_geral);
            envia(valor[s], ^valor[s], 1'b1);
          end
          default: envia(valor[s], ^valor[s], 1'b1);
        endcase
        model_busy = 1'b0;
      end
    end
  end

  // Reference: what one scan should leave behind, from the frame rules.
  task automatic referencia();
    exp_err = '0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'(valor[i]);
      if (v > 100) v = 100;
      case (modo[i])
        M_OK: exp_sens[i] = 7'(v);
        M_PAR: begin
`ifdef UMNI_PARIDADE_EN
          exp_err[i] = 1'b1;
`else
          exp_sens[i] = 7'(v);
`endif
        end
        default: exp_err[i] = 1'b1;
      endcase
    end
  endtask

  task automatic configura_ok();
    for (int i = 0; i < 4; i++) begin
      modo[i]  = M_OK;
      valor[i] = 7'($urandom_range(1, 100));
    end
  endtask

  task automatic run_scan(input bit extra, output bit ok);
    int n;
    referencia();
    cnt_req = 0;
    cnt_val = 0;
    sel_log.delete();
    @(negedge clock_geral);
    iniciar_varredura = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (n < 3000 && !ok) begin
      @(negedge clock_geral);
      n++;
      iniciar_varredura = (extra && n == 40);
      if (amostra_valida === 1'b1) ok = 1'b1;
    end
    iniciar_varredura = 1'b0;
    repeat (40) @(negedge clock_geral);
    n = 0;
    while ((model_busy || req_q.size() != 0) && n < 1000) begin
      @(negedge clock_geral);
      n++;
    end
    repeat (4) @(negedge clock_geral);
  endtask

  task automatic test_reset();
    reset_geral_n     = 1'b0;
    iniciar_varredura = 1'b0;
    for (int i = 0; i < 4; i++) exp_sens[i] = '0;
    repeat (3) @(negedge clock_geral);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== 7'd0) begin
        bad++;
        $display("FAIL reset_sensor%0d got=%0d exp=0", i + 1, obs[i]);
      end
    end
    total++;
    if ({sensor_req, sensor_sel, amostra_valida, erro_sensor, ocupado} !== 9'd0) begin
      bad++;
      $display("FAIL reset_flags got req=%b sel=%0d val=%b err=%b ocup=%b exp all 0",
               sensor_req, sensor_sel, amostra_valida, erro_sensor, ocupado);
    end
    reset_geral_n = 1'b1;
    repeat (3) @(negedge clock_geral);
  endtask

  task automatic test_clean();
    bit ok;
    configura_ok();
    valor[0] = 7'd45; valor[1] = 7'd67; valor[2] = 7'd80; valor[3] = 7'd12;
    run_scan(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clean_done got=no_valid exp=valid"); end
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL clean_err got=%b exp=%b", erro_sensor, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== exp_sens[i]) begin
        bad++; $display("FAIL clean_sensor%0d got=%0d exp=%0d", i + 1, obs[i], exp_sens[i]);
      end
    end
    total++;
    if (cnt_val != 1) begin bad++; $display("FAIL clean_valid_pulses got=%0d exp=1", cnt_val); end
  endtask

  task automatic test_timeout();
    bit ok;
    configura_ok();
    modo[2] = M_MUDO;
    run_scan(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_done got=no_valid exp=valid"); end
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL timeout_err got=%b exp=%b", erro_sensor, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== exp_sens[i]) begin
        bad++; $display("FAIL timeout_sensor%0d got=%0d exp=%0d", i + 1, obs[i], exp_sens[i]);
      end
    end
  endtask

  task automatic test_framing_clamp();
    bit ok;
    configura_ok();
    modo[1] = M_STOP;
    run_scan(1'b0, ok);
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL framing_err got=%b exp=%b", erro_sensor, exp_err);
    end
    total++;
    if (sensor2 !== exp_sens[1]) begin
      bad++; $display("FAIL framing_sensor2 got=%0d exp=%0d", sensor2, exp_sens[1]);
    end
    configura_ok();
    valor[1] = 7'd120;
    run_scan(1'b0, ok);
    total++;
    if (sensor2 !== exp_sens[1]) begin
      bad++; $display("FAIL clamp_sensor2 got=%0d exp=%0d", sensor2, exp_sens[1]);
    end
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL clamp_err got=%b exp=%b", erro_sensor, exp_err);
    end
  endtask

  task automatic test_parity();
    bit ok;
    configura_ok();
    modo[0]  = M_PAR;
    valor[0] = 7'd33;
    run_scan(1'b0, ok);
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL parity_err got=%b exp=%b", erro_sensor, exp_err);
    end
    total++;
    if (sensor1 !== exp_sens[0]) begin
      bad++; $display("FAIL parity_sensor1 got=%0d exp=%0d", sensor1, exp_sens[0]);
    end
  endtask

  task automatic test_glitch();
    bit ok;
    configura_ok();
    modo[3] = M_GLITCH;
    run_scan(1'b0, ok);
    total++;
    if (erro_sensor !== exp_err) begin
      bad++; $display("FAIL glitch_err got=%b exp=%b", erro_sensor, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== exp_sens[i]) begin
        bad++; $display("FAIL glitch_sensor%0d got=%0d exp=%0d", i + 1, obs[i], exp_sens[i]);
      end
    end
  endtask

  task automatic test_back_to_back_trigger();
    bit ok;
    configura_ok();
    run_scan(1'b1, ok);
    total++;
    if (cnt_req != 4) begin bad++; $display("FAIL trig_req_pulses got=%0d exp=4", cnt_req); end
    for (int i = 0; i < sel_log.size() && i < 4; i++) begin
      total++;
      if (sel_log[i] != i) begin
        bad++; $display("FAIL trig_sel%0d got=%0d exp=%0d", i, sel_log[i], i);
      end
    end
    total++;
    if (cnt_val != 1) begin bad++; $display("FAIL trig_valid_pulses got=%0d exp=1", cnt_val); end
    total++;
    if (ocupado !== 1'b0) begin bad++; $display("FAIL trig_ocupado got=%b exp=0", ocupado); end
  endtask

  task automatic test_random();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        modo[i]  = int'($urandom_range(0, 3));
        valor[i] = 7'($urandom_range(0, 127));
      end
      run_scan(1'b0, ok);
      total++;
      if (erro_sensor !== exp_err) begin
        bad++; $display("FAIL rand%0d_err got=%b exp=%b", k, erro_sensor, exp_err);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs[i] !== exp_sens[i]) begin
          bad++; $display("FAIL rand%0d_sensor%0d got=%0d exp=%0d", k, i + 1, obs[i], exp_sens[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    configura_ok();
    cnt_req = 0;
    cnt_val = 0;
    @(negedge clock_geral);
    iniciar_varredura = 1'b1;
    @(negedge clock_geral);
    iniciar_varredura = 1'b0;
    n = 0;
    while (fase != 2 && n < 500) begin
      @(negedge clock_geral);
      n++;
    end
    total++;
    if (fase != 2) begin bad++; $display("FAIL rstmid_frame got=fase%0d exp=fase2", fase); end
    repeat (10) @(negedge clock_geral);
    total++;
    if (ocupado !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", ocupado); end
    #1 reset_geral_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_sens[i] = '0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== 7'd0) begin
        bad++; $display("FAIL rstmid_sensor%0d got=%0d exp=0", i + 1, obs[i]);
      end
    end
    total++;
    if ({sensor_req, sensor_sel, amostra_valida, erro_sensor, ocupado} !== 9'd0) begin
      bad++;
      $display("FAIL rstmid_flags got req=%b sel=%0d val=%b err=%b ocup=%b exp all 0",
               sensor_req, sensor_sel, amostra_valida, erro_sensor, ocupado);
    end
    repeat (3) @(negedge clock_geral);
    reset_geral_n = 1'b1;
    n = 0;
    while ((model_busy || req_q.size() != 0) && n < 1000) begin
      @(negedge clock_geral);
      n++;
    end
    repeat (20) @(negedge clock_geral);
    total++;
    if (cnt_val != 0) begin bad++; $display("FAIL rstmid_valid got=%0d exp=0", cnt_val); end
    total++;
    if (cnt_req != 1) begin bad++; $display("FAIL rstmid_req got=%0d exp=1", cnt_req); end
    total++;
    if (ocupado !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", ocupado); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs[i] !== 7'd0) begin
        bad++; $display("FAIL rstmid_nowrite_sensor%0d got=%0d exp=0", i + 1, obs[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      modo[i]     = M_OK;
      valor[i]    = '0;
      exp_sens[i] = '0;
    end
    test_reset();
    test_clean();
    test_timeout();
    test_framing_clamp();
    test_parity();
    test_glitch();
    test_back_to_back_trigger();
    test_random();
    test_reset_mid();
    test_clean();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/umni_leitor_sensores.md
Name: umni_leitor_sensores

Overview:
- Front end of the UMNI humidifier: polls the four humidity sensors over one shared single-wire serial line.
- Deserializes each sensor's reply and presents sensor1..sensor4 as registered 7-bit values.
- These outputs feed the UMNI averaging and display path directly.
- UMNI consumes sensor values; this block is the reader that produces them from the sensor-side serial writer.

Parameters:
- BIT_CICLOS, 50, clock cycles per serial bit (>=4, even)
- TIMEOUT_CICLOS, 2000, max cycles from request to start-bit falling edge
- PERIODO_VARREDURA, 100000, cycles between automatic scan starts (0 = manual only)

Ports:
- clock_geral  in  1  system clock
- reset_geral_n  in  1  asynchronous active-low reset
- iniciar_varredura  in  1  one-cycle pulse, starts a scan if idle
- sensor_dado  in  1  shared serial line, idle high, asynchronous to clock_geral
- sensor_req  out  1  one-cycle request pulse to the addressed sensor
- sensor_sel  out  2  address of sensor being read (0..3)
- sensor1, sensor2, sensor3, sensor4  out  7 each  last good humidity per sensor
- amostra_valida  out  1  one-cycle pulse when a full scan ends
- erro_sensor  out  4  per-sensor error flags of the last scan (bit i = sensor i+1)
- ocupado  out  1  high while a scan is in progress

Behaviour:
- Reset values:
  - all sensorN = 0; erro_sensor = 0; sensor_req = 0; sensor_sel = 0; amostra_valida = 0; ocupado = 0.
  - State = OCIOSO; period counter = 0.
- Input conditioning:
  - sensor_dado passes through a 2-flop synchronizer (reset to 1).
  - All decoding uses the synchronized value, so line-to-decision latency is 2 cycles.
- Frame, sent by a sensor after its request:
  - start bit 0
  - 7 data bits, LSB first
  - 1 even-parity bit over the data
  - stop bit 1
  - each bit lasts BIT_CICLOS cycles
- Scan trigger:
  - iniciar_varredura pulse, or the period counter reaching PERIODO_VARREDURA-1 (counter then wraps to 0).
  - Triggers while ocupado=1 are ignored.
  - Trigger and scan end in the same cycle: the trigger is ignored.
- FSM states and transitions:
  - OCIOSO -> REQUISITA on trigger. ocupado rises next cycle; indice=0; the scan's error accumulator is cleared.
  - REQUISITA: sensor_req=1 for exactly one cycle with sensor_sel=indice -> ESPERA_START.
  - ESPERA_START: waits for synchronized line = 0. Timeout after TIMEOUT_CICLOS cycles -> FALHA.
  - START: waits BIT_CICLOS/2 cycles, resamples. Still 0 -> DADOS; 1 (glitch) -> FALHA.
  - DADOS: samples every BIT_CICLOS cycles at mid-bit; shifts into a 7-bit register, LSB first; after 7 bits -> PARIDADE.
  - PARIDADE: samples the parity bit -> STOP.
  - STOP: samples. Line 1 -> ARMAZENA; line 0 (framing error) -> FALHA.
  - ARMAZENA: writes sensor[indice] (subject to the optional feature) -> PROXIMO.
  - FALHA: sets accumulator bit indice; sensor[indice] keeps its old value -> PROXIMO.
  - PROXIMO: if indice=3 -> OCIOSO, else indice+1 -> REQUISITA.
- Scan end:
  - On the PROXIMO->OCIOSO transition: amostra_valida pulses for 1 cycle, erro_sensor loads the accumulator, ocupado drops.
- Value rule: received value > 100 is clamped to 100 before storing.
- Timing:
  - sensorN updates one cycle after the stop-bit sample.
  - All outputs are registered.
- Reset mid-frame:
  - Immediate return to OCIOSO with reset values; no partial write.
  - After reset the line is ignored until the next trigger.

Optional Feature:
- Macro: UMNI_PARIDADE_EN.
- Defined:
  - A parity mismatch in the PARIDADE state routes to FALHA after the stop bit is consumed.
  - The FSM still waits out the stop bit so the line stays aligned.
- Undefined:
  - The parity bit is sampled and discarded.
  - Only timeout, start glitch and framing errors set erro_sensor.

Decomposition:
- Shared package umni_pkg:
  - FSM state encoding
  - UMIDADE_MAX = 100
  - sensor index width (2)
- Sub-module umni_rx_bit: synchronizer plus mid-bit sample-tick counter. Outputs the synchronized line, a falling-edge strobe and the sample strobe.
- The FSM and storage stay in the top module.

Test Plan (bench BIT_CICLOS=8, TIMEOUT_CICLOS=64, PERIODO_VARREDURA=0):
- Clean scan: sensor models reply 45, 67, 80, 12 with correct parity -> sensor1..4 = 45, 67, 80, 12; one amostra_valida pulse; erro_sensor=0000.
- Timeout: sensor 3 silent -> erro_sensor=0100; sensor3 keeps its previous value; sensors 1, 2, 4 update; the scan still completes.
- Framing and clamp: sensor 2 stop bit driven 0 -> erro_sensor=0010. In the next scan sensor 2 sends 120 -> sensor2=100.
- Parity: sensor 1 sends 33 with bad parity. With UMNI_PARIDADE_EN -> erro_sensor=0001, sensor1 unchanged. Without it -> sensor1=33, erro_sensor=0000.
- Start glitch, triggers and reset:
  - 2-cycle low pulse before a real frame -> FALHA for that sensor.
  - A second iniciar_varredura while ocupado=1 is ignored: exactly 4 sensor_req pulses, sensor_sel 0, 1, 2, 3.
  - reset_geral_n asserted during DADOS -> all outputs 0 immediately, no amostra_valida.
